// File: rtl/sync_frame_serializer_if.sv
// rtl/sync_frame_serializer_if.sv - parallel word handshake into the frame serializer
interface sync_frame_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sync_frame_serializer.sv
// rtl/sync_frame_serializer.sv - serializes words as 1011 preamble, MSB-first payload, even parity, idle gap
module sync_frame_serializer #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    sync_frame_serializer_if.slave  tx,
    output logic                    data_out,
    output logic                    bit_strobe,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int MB0  = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAXB = (GAP_BITS > MB0) ? GAP_BITS : MB0;
    localparam int IW   = $clog2(MAXB + 1);
    localparam logic [3:0] PREAMBLE = 4'b1011;

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

    state_t            state, adv_state;
    logic [CW-1:0]     cyc;
    logic [IW-1:0]     idx, adv_idx;
    logic [DATA_W-1:0] word;
    logic              parity;
    logic              last_cyc, last_bit, frame_end, adv_final;

    function automatic int bit_count(state_t s);
        case (s)
            PRE:     return 4;
            DATA:    return DATA_W;
            PAR:     return 1;
            GAP:     return GAP_BITS;
            default: return 1;
        endcase
    endfunction

    // Optional states are skipped here, so the sequencing below never sees them.
    function automatic state_t after(state_t s);
        state_t n;
        n = IDLE;
        case (s)
            PRE:  n = DATA;
            DATA: begin
                if (PARITY_EN != 0)    n = PAR;
                else if (GAP_BITS > 0) n = GAP;
            end
            PAR:  if (GAP_BITS > 0) n = GAP;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic bit_value(state_t s, logic [IW-1:0] i,
                                       logic [DATA_W-1:0] w, logic p);
        logic [3:0]        pre_sh;
        logic [DATA_W-1:0] w_sh;
        pre_sh = PREAMBLE << i;
        w_sh   = w << i;
        case (s)
            PRE:     return pre_sh[3];
            DATA:    return w_sh[DATA_W-1];
            PAR:     return p;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        last_cyc  = (int'(cyc) == BIT_CYCLES - 1);
        last_bit  = (int'(idx) == bit_count(state) - 1);
        frame_end = last_bit && (after(state) == IDLE);
        adv_state = state;
        adv_idx   = idx + 1'b1;
        if (last_bit) begin
            adv_state = after(state);
            adv_idx   = '0;
        end
        adv_final = (int'(adv_idx) == bit_count(adv_state) - 1) && (after(adv_state) == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cyc         <= '0;
            idx         <= '0;
            word        <= '0;
            parity      <= 1'b0;
            data_out    <= 1'b0;
            bit_strobe  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            tx.tx_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    data_out   <= 1'b0;
                    bit_strobe <= 1'b0;
                    frame_done <= 1'b0;
                    if (tx.tx_valid && tx.tx_ready) begin
                        word        <= tx.tx_data;
                        parity      <= ^tx.tx_data;
                        state       <= PRE;
                        idx         <= '0;
                        cyc         <= '0;
                        data_out    <= PREAMBLE[3];
                        bit_strobe  <= 1'b1;
                        busy        <= 1'b1;
                        tx.tx_ready <= 1'b0;
                    end
                end
                default: begin
                    if (!last_cyc) begin
                        cyc        <= cyc + 1'b1;
                        bit_strobe <= 1'b0;
                        frame_done <= frame_end && (int'(cyc) + 2 == BIT_CYCLES);
                    end else if (frame_end) begin
                        state       <= IDLE;
                        cyc         <= '0;
                        idx         <= '0;
                        data_out    <= 1'b0;
                        bit_strobe  <= 1'b0;
                        busy        <= 1'b0;
                        frame_done  <= 1'b0;
                        tx.tx_ready <= 1'b1;
                    end else begin
                        // frame_done is raised one edge early so it lines up with the final cycle.
                        state      <= adv_state;
                        idx        <= adv_idx;
                        cyc        <= '0;
                        data_out   <= bit_value(adv_state, adv_idx, word, parity);
                        bit_strobe <= 1'b1;
                        frame_done <= adv_final && (BIT_CYCLES == 1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sync_frame_serializer.sv
// tb/tb_sync_frame_serializer.sv - directed checks of sync_frame_serializer across three parameter sets
module tb_sync_frame_serializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sync_frame_serializer_if #(.DATA_W(8)) if0 ();
    sync_frame_serializer_if #(.DATA_W(8)) if1 ();
    sync_frame_serializer_if #(.DATA_W(8)) if2 ();

    logic do0, bs0, busy0, fd0;
    logic do1, bs1, busy1, fd1;
    logic do2, bs2, busy2, fd2;

    sync_frame_serializer u0 (
        .clk(clk), .reset(reset), .tx(if0.slave),
        .data_out(do0), .bit_strobe(bs0), .busy(busy0), .frame_done(fd0));

    sync_frame_serializer #(.BIT_CYCLES(3)) u1 (
        .clk(clk), .reset(reset), .tx(if1.slave),
        .data_out(do1), .bit_strobe(bs1), .busy(busy1), .frame_done(fd1));

    sync_frame_serializer #(.PARITY_EN(0), .GAP_BITS(0)) u2 (
        .clk(clk), .reset(reset), .tx(if2.slave),
        .data_out(do2), .bit_strobe(bs2), .busy(busy2), .frame_done(fd2));

    // Reference 1011 detector fed by u0's line.
    logic [3:0] sr = 4'b0000;
    logic       det;
    int         det_count = 0;
    assign det = (sr == 4'b1011);
    always @(posedge clk) begin
        sr <= {sr[2:0], do0};
        if (det) det_count <= det_count + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame0(input logic [14:0] exp, input bit toggle);
        for (int i = 0; i < 15; i++) begin
            chk("f0_data",   do0, exp[14-i]);
            chk("f0_strobe", bs0, 1);
            chk("f0_done",   fd0, i == 14);
            chk("f0_busy",   busy0, 1);
            chk("f0_ready",  if0.tx_ready, 0);
            chk("f0_det",    det, i == 4);
            if (toggle) if0.tx_data = 8'($urandom);
            if (i < 14) tick();
        end
    endtask

    task automatic frame1(input logic [14:0] exp);
        for (int i = 0; i < 45; i++) begin
            chk("f1_data",   do1, exp[14-(i/3)]);
            chk("f1_strobe", bs1, (i % 3) == 0);
            chk("f1_done",   fd1, i == 44);
            if (i < 44) tick();
        end
    endtask

    initial begin
        int fd_seen;
        int c0;
        logic [11:0] exp2;

        reset = 1'b1;
        if0.tx_valid = 1'b0; if0.tx_data = 8'h00;
        if1.tx_valid = 1'b0; if1.tx_data = 8'h00;
        if2.tx_valid = 1'b0; if2.tx_data = 8'h00;
        tick();
        tick();
        chk("rst_data",  do0, 0);
        chk("rst_strb",  bs0, 0);
        chk("rst_busy",  busy0, 0);
        chk("rst_done",  fd0, 0);
        chk("rst_ready", if0.tx_ready, 1);
        reset = 1'b0;
        tick();

        // 0xA5 with defaults
        if0.tx_data = 8'hA5; if0.tx_valid = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        frame0(15'b1011_10100101_0_00, 1'b0);
        tick();
        chk("a5_ready", if0.tx_ready, 1);
        chk("a5_busy",  busy0, 0);
        chk("a5_done",  fd0, 0);

        // valid held high: 0x3C then 0xC3, data toggling mid-frame
        if0.tx_data = 8'h3C; if0.tx_valid = 1'b1;
        tick();
        frame0(15'b1011_00111100_0_00, 1'b1);
        if0.tx_data = 8'hC3;
        tick();
        chk("b2b_ready", if0.tx_ready, 1);
        chk("b2b_busy",  busy0, 0);
        tick();
        if0.tx_valid = 1'b0;
        frame0(15'b1011_11000011_0_00, 1'b0);
        tick();

        // reset at the 3rd payload bit of 0x3A
        if0.tx_data = 8'h3A; if0.tx_valid = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_bit", do0, 1);
        reset = 1'b1;
        tick();
        chk("abort_data",  do0, 0);
        chk("abort_busy",  busy0, 0);
        chk("abort_ready", if0.tx_ready, 1);
        chk("abort_done",  fd0, 0);
        reset = 1'b0;
        fd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (fd0) fd_seen++;
            tick();
        end
        chk("abort_no_done", fd_seen, 0);
        if0.tx_data = 8'h55; if0.tx_valid = 1'b1;
        tick();
        if0.tx_valid = 1'b0;
        frame0(15'b1011_01010101_0_00, 1'b0);
        tick();

        // loopback: three 0x00 frames back to back
        c0 = det_count;
        if0.tx_data = 8'h00; if0.tx_valid = 1'b1;
        tick();
        frame0(15'b1011_00000000_0_00, 1'b0);
        tick();
        tick();
        frame0(15'b1011_00000000_0_00, 1'b0);
        tick();
        tick();
        if0.tx_valid = 1'b0;
        frame0(15'b1011_00000000_0_00, 1'b0);
        tick();
        tick();
        chk("det_count", det_count - c0, 3);

        // BIT_CYCLES=3: 0xFF then 0x01
        if1.tx_data = 8'hFF; if1.tx_valid = 1'b1;
        tick();
        if1.tx_valid = 1'b0;
        frame1(15'b1011_11111111_0_00);
        tick();
        chk("bc3_ready", if1.tx_ready, 1);
        chk("bc3_busy",  busy1, 0);
        if1.tx_data = 8'h01; if1.tx_valid = 1'b1;
        tick();
        if1.tx_valid = 1'b0;
        frame1(15'b1011_00000001_1_00);
        tick();
        chk("bc3_ready2", if1.tx_ready, 1);

        // no parity, no gap: 0x0F
        exp2 = 12'b1011_00001111;
        if2.tx_data = 8'h0F; if2.tx_valid = 1'b1;
        tick();
        if2.tx_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("np_data",   do2, exp2[11-i]);
            chk("np_strobe", bs2, 1);
            chk("np_done",   fd2, i == 11);
            if (i < 11) tick();
        end
        tick();
        chk("np_ready", if2.tx_ready, 1);
        chk("np_busy",  busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
